// File: rtl/sr_ff_bist.sv
// Self-test sequencer for an SR flip-flop.
// Drives a fixed 6-vector S/R sequence into the flip-flop under test, waits for each response
// to settle, and compares Q/QN against the expected values.
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      one-cycle run request, honoured only in IDLE or DONE
//   S, R       registered set/reset drive to the flip-flop under test
//   Q, QN      flip-flop outputs under test
//   busy       high while the sequence runs
//   done       high in DONE until the next start or reset
//   pass/fail  result, valid with done
//   err_count  number of failing vectors
//   err_index  index of the first failing vector, 7 when none failed
module sr_ff_bist #(
  parameter int unsigned SETTLE_CYCLES = 1  // 1..7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       S,
  output logic       R,
  input  logic       Q,
  input  logic       QN,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [2:0] err_count,
  output logic [2:0] err_index
);

  typedef enum logic [2:0] {StIdle, StApply, StWait, StCheck, StDone} state_e;

  localparam logic [2:0] LastIdx = 3'd5;
  localparam logic [2:0] NoIdx   = 3'd7;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] wait_q, wait_d;
  logic       s_q, s_d, r_q, r_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       pass_q, pass_d, fail_q, fail_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] eidx_q, eidx_d;
  logic       mismatch;

  // {S, R} drive for each vector index.
  function automatic logic [1:0] vec_sr(input logic [2:0] i);
    unique case (i)
      3'd0:    vec_sr = 2'b10;
      3'd1:    vec_sr = 2'b01;
      3'd2:    vec_sr = 2'b10;
      3'd3:    vec_sr = 2'b00;
      3'd4:    vec_sr = 2'b01;
      default: vec_sr = 2'b11;  // forbidden input, exercised but not checked
    endcase
  endfunction

  function automatic logic vec_exp(input logic [2:0] i);
    unique case (i)
      3'd0:    vec_exp = 1'b1;
      3'd1:    vec_exp = 1'b0;
      3'd2:    vec_exp = 1'b1;
      3'd3:    vec_exp = 1'b1;
      default: vec_exp = 1'b0;
    endcase
  endfunction

  // Case inequality so X/Z on Q or QN is flagged in simulation.
  always_comb begin
    mismatch = (Q !== vec_exp(idx_q)) || (QN !== ~Q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    s_d     = s_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    cnt_d   = cnt_q;
    eidx_d  = eidx_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StApply;
          idx_d      = 3'd0;
          {s_d, r_d} = vec_sr(3'd0);
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          cnt_d      = 3'd0;
          eidx_d     = NoIdx;
        end
      end
      StApply: begin
        state_d = StWait;
        wait_d  = 3'(SETTLE_CYCLES);
      end
      StWait: begin
        if (wait_q <= 3'd1) begin
          state_d = StCheck;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      StCheck: begin
        if (idx_q != LastIdx) begin
          if (mismatch) begin
            cnt_d = cnt_q + 3'd1;
            if (eidx_q == NoIdx) eidx_d = idx_q;
          end
          idx_d      = idx_q + 3'd1;
          {s_d, r_d} = vec_sr(idx_q + 3'd1);
          state_d    = StApply;
        end else begin
          // Last vector is exercise-only, so the count is already final.
          state_d = StDone;
          s_d     = 1'b0;
          r_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (cnt_q == 3'd0);
          fail_d  = (cnt_q != 3'd0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      wait_q  <= 3'd0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      cnt_q   <= 3'd0;
      eidx_q  <= NoIdx;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      eidx_q  <= eidx_d;
    end
  end

  assign S         = s_q;
  assign R         = r_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign err_count = cnt_q;
  assign err_index = eidx_q;

endmodule

// File: tb/tb_sr_ff_bist.sv
// Bench for sr_ff_bist: two instances (settle 1 and settle 3) each drive a behavioural SR
// flip-flop with selectable faults. Expected run results are queued at start; monitors compare
// on each rising done.
module tb_sr_ff_bist;

  typedef struct {
    int         cyc;
    logic       p;
    logic       f;
    logic [2:0] cnt;
    logic [2:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start3 = 1'b0;
  logic s1, r1, q1, qn1, busy1, done1, pass1, fail1;
  logic s3, r3, q3, qn3, busy3, done3, pass3, fail3;
  logic [2:0] cnt1, idx1, cnt3, idx3;
  logic ff1 = 1'b0, ff3 = 1'b0;
  logic done1_prev = 1'b0, done3_prev = 1'b0;
  int   fault1 = 0;  // 0 good, 1 Q stuck at 0, 2 QN tied to Q
  int   cyc = 0;
  int   n_vec = 0, n_miss = 0;
  exp_t q1_exp[$], q3_exp[$];
  logic [1:0] sr_tab [6] = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b11};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr_ff_bist #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .S(s1), .R(r1), .Q(q1), .QN(qn1),
    .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .err_count(cnt1), .err_index(idx1)
  );

  sr_ff_bist #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .S(s3), .R(r3), .Q(q3), .QN(qn3),
    .busy(busy3), .done(done3), .pass(pass3), .fail(fail3), .err_count(cnt3), .err_index(idx3)
  );

  // Behavioural SR flip-flops under test.
  always @(posedge clk) begin
    if (s1 && !r1) ff1 <= 1'b1;
    else if (r1 && !s1) ff1 <= 1'b0;
    else if (s1 && r1) ff1 <= 1'b0;
    if (s3 && !r3) ff3 <= 1'b1;
    else if (r3 && !s3) ff3 <= 1'b0;
    else if (s3 && r3) ff3 <= 1'b0;
  end
  assign q1  = (fault1 == 1) ? 1'b0 : ff1;
  assign qn1 = (fault1 == 2) ? q1 : ~q1;
  assign q3  = ff3;
  assign qn3 = ~ff3;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: compare each completed run against the queued expectation.
  always @(negedge clk) begin
    done1_prev <= done1;
    done3_prev <= done3;
    if (done1 && !done1_prev) begin
      if (q1_exp.size() == 0) begin
        chk("dut1_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q1_exp.pop_front();
        chk("dut1_latency", cyc, e.cyc);
        chk("dut1_pass", int'(pass1), int'(e.p));
        chk("dut1_fail", int'(fail1), int'(e.f));
        chk("dut1_err_count", int'(cnt1), int'(e.cnt));
        chk("dut1_err_index", int'(idx1), int'(e.idx));
        chk("dut1_sr_idle", int'({s1, r1}), 0);
      end
    end
    if (done3 && !done3_prev) begin
      if (q3_exp.size() == 0) begin
        chk("dut3_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q3_exp.pop_front();
        chk("dut3_latency", cyc, e.cyc);
        chk("dut3_pass", int'(pass3), int'(e.p));
        chk("dut3_fail", int'(fail3), int'(e.f));
        chk("dut3_err_count", int'(cnt3), int'(e.cnt));
        chk("dut3_err_index", int'(idx3), int'(e.idx));
      end
    end
  end

  // Pulse start on dut1 and optionally queue the expected result.
  task automatic run1(input bit push, input logic p, input logic [2:0] cnt, input logic [2:0] idx);
    exp_t e;
    e.cyc = cyc + 1 + 18;
    e.p = p; e.f = ~p; e.cnt = cnt; e.idx = idx;
    if (push) q1_exp.push_back(e);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_empty(input int which, input int budget);
    int n = 0;
    while (((which == 1) ? q1_exp.size() : q3_exp.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk($sformatf("dut%0d_done_timeout", which), 0, 1);
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_busy"}, int'(busy1), 0);
    chk({tag, "_done"}, int'(done1), 0);
    chk({tag, "_pass"}, int'(pass1), 0);
    chk({tag, "_fail"}, int'(fail1), 0);
    chk({tag, "_err_count"}, int'(cnt1), 0);
    chk({tag, "_err_index"}, int'(idx1), 7);
    chk({tag, "_sr"}, int'({s1, r1}), 0);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    chk_reset1("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Good run: check the S/R sequence, each vector held three cycles.
    run1(1'b1, 1'b1, 3'd0, 3'd7);
    for (int j = 0; j < 18; j++) begin
      chk($sformatf("sr_seq_%0d", j), int'({s1, r1}), int'(sr_tab[j / 3]));
      chk($sformatf("busy_%0d", j), int'(busy1), 1);
      @(negedge clk);
    end
    wait_empty(1, 10);
    chk("done_hold_sr", int'({s1, r1}), 0);

    // Q stuck at 0: vectors 0, 2, 3 fail.
    fault1 = 1;
    run1(1'b1, 1'b0, 3'd3, 3'd0);
    wait_empty(1, 40);

    // Back-to-back restart from a failing DONE clears results at the start edge.
    fault1 = 0;
    run1(1'b1, 1'b1, 3'd0, 3'd7);
    chk("restart_done", int'(done1), 0);
    chk("restart_fail", int'(fail1), 0);
    chk("restart_err_count", int'(cnt1), 0);
    chk("restart_err_index", int'(idx1), 7);
    chk("restart_busy", int'(busy1), 1);
    wait_empty(1, 40);

    // QN tied to Q: every checked vector fails the complement check.
    fault1 = 2;
    run1(1'b1, 1'b0, 3'd5, 3'd0);
    wait_empty(1, 40);
    fault1 = 0;

    // Reset during vector 2, then a full clean run.
    run1(1'b0, 1'b1, 3'd0, 3'd7);
    repeat (6) @(negedge clk);
    chk("pre_reset_sr_vec2", int'({s1, r1}), int'(sr_tab[2]));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset1("midrun_reset");
    repeat (25) @(negedge clk);
    chk("post_reset_idle_busy", int'(busy1), 0);
    run1(1'b1, 1'b1, 3'd0, 3'd7);
    wait_empty(1, 40);

    // Settle 3: starts while busy at cycles 4 and 10 are ignored.
    e.cyc = cyc + 1 + 30; e.p = 1'b1; e.f = 1'b0; e.cnt = 3'd0; e.idx = 3'd7;
    q3_exp.push_back(e);
    start3 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start3 = (k == 3 || k == 9);
    end
    start3 = 1'b0;
    wait_empty(3, 60);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
